// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the instruction-fetch cache responder.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines);
    return addr_w - 2 - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped one-word line store: combinational lookup, single write port,
// and a clear-all that invalidates every line.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32,
  localparam int IDX      = idx_w(NUM_LINES),
  localparam int TW       = tag_w(ADDR_W, NUM_LINES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_all,
  input  logic [IDX-1:0] rd_idx,
  input  logic [TW-1:0]  rd_tag,
  output logic           rd_hit,
  output logic [31:0]    rd_data,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic [TW-1:0]  wr_tag,
  input  logic [31:0]    wr_data
);

  logic [31:0]          data_mem [NUM_LINES];
  logic [TW-1:0]        tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  // A clear in the same cycle as a fill wins: the filled line stays invalid.
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/icache_fetch_responder.sv
// Instruction-fetch responder: serves hits from the line array and fetches
// misses over the memory req/ack bus, with kill (edge) and flush (level).
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic              if_kill_i,
  input  logic              if_flush_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [31:0]       if_inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int IDX = idx_w(NUM_LINES);
  localparam int TW  = tag_w(ADDR_W, NUM_LINES);

  state_t      state;
  logic        kill_q;
  logic        valid_q;
  logic        nofill_q;
  logic        kill_rise;
  logic        accept;
  logic        hit;
  logic        fill_en;
  logic [31:0] hit_data;
  logic        unused_addr_lsb;

  assign kill_rise       = if_kill_i & ~kill_q;
  assign if_valid_o      = valid_q & ~kill_rise;
  assign accept          = (state == IDLE) & if_req_i & ~if_valid_o & ~if_flush_i;
  assign fill_en         = (state == MISS) & mem_ack_i & ~kill_rise & ~nofill_q;
  assign unused_addr_lsb = ^if_addr_i[1:0];

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .clear_all (if_flush_i),
    .rd_idx    (if_addr_i[2+IDX-1:2]),
    .rd_tag    (if_addr_i[ADDR_W-1:2+IDX]),
    .rd_hit    (hit),
    .rd_data   (hit_data),
    .wr_en     (fill_en),
    .wr_idx    (mem_addr_o[2+IDX-1:2]),
    .wr_tag    (mem_addr_o[ADDR_W-1:2+IDX]),
    .wr_data   (mem_rdata_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      nofill_q   <= 1'b0;
      if_inst_o  <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      kill_q  <= if_kill_i;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              valid_q   <= 1'b1;
              if_inst_o <= hit_data;
            end else begin
              state      <= MISS;
              mem_req_o  <= 1'b1;
              mem_addr_o <= {if_addr_i[ADDR_W-1:2], 2'b00};
            end
          end
        end
        MISS: begin
          // A flush mid-miss still answers the requester but must not refill.
          if (if_flush_i) nofill_q <= 1'b1;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            nofill_q  <= 1'b0;
            if (!kill_rise) begin
              valid_q   <= 1'b1;
              if_inst_o <= mem_rdata_i;
            end
          end else if (kill_rise) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The bus transaction cannot be aborted; swallow its ack.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= IDLE;
            nofill_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Responder end of the instruction-fetch request interface: the cache the fetch-side realigner talks to.
- Accepts word fetch requests with kill and flush.
- Serves hits from a small direct-mapped array; fetches misses from the memory bus over a req/ack handshake.
- Sits between the fetch stage and the instruction memory.

Parameters:
- NUM_LINES, 16, number of one-word lines; power of two, minimum 2.
- ADDR_W, 32, fetch/memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held high with if_addr_i stable until if_valid_o
- if_kill_i  in  1  cancel in-flight request; rising edge significant
- if_flush_i  in  1  invalidate all lines
- if_addr_i  in  ADDR_W  fetch address; bits [1:0] ignored
- if_valid_o  out  1  one-cycle response strobe
- if_inst_o  out  32  instruction word for the accepted request
- mem_req_o  out  1  memory read request, held until ack
- mem_addr_o  out  ADDR_W  word-aligned memory address
- mem_ack_i  in  1  single-cycle ack; mem_rdata_i valid same cycle
- mem_rdata_i  in  32  memory read data

Behaviour:
- Address split: word = addr[ADDR_W-1:2]; index = addr[2+IDX-1:2] with IDX = log2(NUM_LINES); tag = remaining upper bits. The block always returns the aligned word {addr[ADDR_W-1:2],2'b00}. Halfword realignment is the requester's job.
- Storage: data[NUM_LINES]x32, tag[NUM_LINES], valid[NUM_LINES]. Reset clears valid only.
- Reset values: if_valid_o=0, if_inst_o=0, mem_req_o=0, mem_addr_o=0, state=IDLE, all valid bits 0, kill_q=0.
- kill_rise = if_kill_i & ~kill_q. kill_q is a register of if_kill_i.
- FSM states: IDLE, MISS, DRAIN.
- IDLE:
  - A request is accepted when if_req_i=1, if_valid_o=0 this cycle, and there is no flush this cycle.
  - Hit: the response is registered; if_valid_o=1 with data in the next cycle (latency 1).
  - Miss: go to MISS. mem_req_o=1 and mem_addr_o = word-aligned addr from the next cycle.
  - Back-to-back hits: at most one accept every 2 cycles.
- MISS:
  - mem_req_o and mem_addr_o stay stable until mem_ack_i.
  - On ack: write data/tag, set valid (unless nofill_q is set), drop mem_req_o next cycle, return to IDLE.
  - if_valid_o=1 with mem_rdata_i in the cycle after ack (miss latency = ack cycle + 1).
- DRAIN:
  - mem_req_o is held until mem_ack_i.
  - Returned data is discarded: no fill, no if_valid_o.
  - Go to IDLE after the ack. A held if_req_i is then accepted as a new request.
- Kill (kill_rise):
  - In MISS: go to DRAIN.
  - In IDLE with a registered response pending: if_valid_o is suppressed combinationally (if_valid_o = valid_q & ~kill_rise).
  - If if_req_i is also high in the kill_rise cycle in IDLE, the request is accepted normally.
  - If if_req_i is high while the block is in MISS/DRAIN, it is accepted after the drain completes.
  - A kill held high causes no further cancels.
- Flush (level):
  - Clears all valid bits at the next edge; no request is accepted that cycle.
  - In MISS: sets nofill_q. The response is still delivered to the requester but not written to the array. nofill_q clears on return to IDLE.
  - In DRAIN: valid bits are cleared; the state is unchanged.
- Priority: reset > flush > kill_rise > if_req_i.
- Same-cycle ack and kill_rise in MISS: the data is discarded with no fill and no valid; go to IDLE.
- Protocol violations (address change while waiting, without kill): undefined, flagged by a bench assertion.
- Reset mid-transaction: all outputs return to reset values at the next edge. The memory side is reset together with the block.
- if_inst_o holds its last value when if_valid_o=0.

Decomposition:
- Package icache_pkg: state enum {IDLE, MISS, DRAIN}; NOP constant 32'h0000_0013; IDX/tag width localparam functions of NUM_LINES/ADDR_W.
- One sub-module, icache_line_array: valid/tag/data storage with a combinational lookup port, one write port, and a clear-all input.

Test Plan:
- Miss: reset, req 0x100, mem acks 3 cycles after mem_req_o with 0x00A00093 -> mem_addr_o=0x100; if_valid_o=1 with 0x00A00093 in the cycle after ack, exactly once.
- Hit: req 0x100 again -> if_valid_o next cycle with 0x00A00093; mem_req_o stays 0.
- Misaligned/conflict:
  - Req 0x102 after the miss test -> hit returning the word at 0x100.
  - Req 0x140 (same index) -> miss at mem_addr_o=0x140, data 0x00000013.
  - Req 0x100 afterwards -> misses again.
- Kill during miss:
  - Req 0x200 miss; kill rises with req 0x300 held -> ack for 0x200 (0xDEADBEEF) produces no if_valid_o and no fill.
  - Then mem_addr_o=0x300; valid with its data.
  - Later req 0x200 misses.
- Flush during miss: hit 0x100, then req 0x400 miss with flush pulsed mid-miss -> 0x400 data delivered; subsequent reqs 0x100 and 0x400 both miss.
- Reset mid-miss: assert reset while mem_req_o=1 -> next cycle mem_req_o=0, if_valid_o=0, state IDLE; req 0x100 then misses.
